sd_block_reader: RTL

- Byte-level sequencer sitting directly upstream of the floppy subsystem's SPI host.
- Issues an SD CMD17 (READ_SINGLE_BLOCK) one byte at a time through the host's byte interface (di/wr/do/dsr).
- Parses the R1 response and the 0xFE start token, then streams the 512 data bytes to the floppy sector buffer with a byte index.
- Drives card chip-select and reports done/error to the floppy controller.

---
 rtl/sd_block_reader.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/sd_block_reader.sv
// sd_block_reader: issues SD CMD17 byte by byte through an SPI host, parses R1 and the
// start token, and streams one data block out. Define SD_CRC16_EN to check the block CRC-16.
module sd_block_reader #(
    parameter int R1_TRIES    = 8,
    parameter int TOKEN_TRIES = 4095,
    parameter int BLOCK_BYTES = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        start,
    input  logic [31:0] lba,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        cs_n,
    output logic [7:0]  spi_di,
    output logic        spi_wr,
    input  logic [7:0]  spi_do,
    input  logic        spi_dsr,
    output logic [7:0]  dout,
    output logic        dout_we,
    output logic [8:0]  dout_addr,
    output logic        crc_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_TRAIL, S_OK, S_FAIL
    } state_t;

    localparam logic [11:0] R1_LAST    = 12'(R1_TRIES - 1);
    localparam logic [11:0] TOKEN_LAST = 12'(TOKEN_TRIES - 1);
    localparam logic [8:0]  IDX_LAST   = 9'(BLOCK_BYTES - 1);

    state_t      state_q, state_d;
    logic        wait_q, wait_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] poll_q, poll_d;
    logic [8:0]  idx_q, idx_d;
    logic [31:0] lba_q, lba_d;
    logic [1:0]  code_q, code_d;
    logic        xfer_active;
    logic        byte_done;

    // Host byte handshake: spi_wr (with spi_di) is the request and is taken on the edge where
    // ce=1, so ce acts as ready; the reply byte on spi_do is valid only in the cycle spi_dsr=1.
    // spi_di stays stable from the request until that reply.
    assign xfer_active = state_q inside {S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_TRAIL};
    assign byte_done   = xfer_active && wait_q && spi_dsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wait_q  <= 1'b0;
            cnt_q   <= '0;
            poll_q  <= '0;
            idx_q   <= '0;
            lba_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            poll_q  <= poll_d;
            idx_q   <= idx_d;
            lba_q   <= lba_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        poll_d    = poll_q;
        idx_d     = idx_q;
        lba_d     = lba_q;
        code_d    = code_q;
        busy      = xfer_active;
        done      = (state_q == S_OK);
        err       = (state_q == S_FAIL);
        err_code  = code_q;
        cs_n      = !(state_q inside {S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC});
        spi_wr    = xfer_active && !wait_q;
        spi_di    = 8'hFF;
        dout_we   = (state_q == S_DATA) && byte_done;
        dout      = dout_we ? spi_do : 8'h00;
        dout_addr = idx_q;

        if (xfer_active && !wait_q && ce) wait_d = 1'b1;
        if (byte_done) wait_d = 1'b0;

        if (state_q == S_CMD) begin
            case (cnt_q)
                3'd0:    spi_di = 8'h51;
                3'd1:    spi_di = lba_q[31:24];
                3'd2:    spi_di = lba_q[23:16];
                3'd3:    spi_di = lba_q[15:8];
                3'd4:    spi_di = lba_q[7:0];
                default: spi_di = 8'hFF;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lba_d   = lba;
                    code_d  = 2'd0;
                    cnt_d   = 3'd0;
                    idx_d   = 9'd0;
                    wait_d  = 1'b0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (byte_done) begin
                    if (cnt_q == 3'd5) begin
                        cnt_d   = 3'd0;
                        poll_d  = 12'd0;
                        state_d = S_R1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_R1: begin
                if (byte_done) begin
                    if (spi_do == 8'hFF) begin
                        if (poll_q == R1_LAST) begin
                            code_d  = 2'd2;
                            state_d = S_FAIL;
                        end else begin
                            poll_d = poll_q + 12'd1;
                        end
                    end else if (spi_do == 8'h00) begin
                        poll_d  = 12'd0;
                        state_d = S_TOKEN;
                    end else begin
                        code_d  = 2'd1;
                        state_d = S_FAIL;
                    end
                end
            end
            S_TOKEN: begin
                if (byte_done) begin
                    if (spi_do == 8'hFE) begin
                        idx_d   = 9'd0;
                        state_d = S_DATA;
                    end else if (spi_do == 8'hFF && poll_q != TOKEN_LAST) begin
                        poll_d = poll_q + 12'd1;
                    end else begin
                        // error token, or the poll budget ran out on a filler byte
                        code_d  = 2'd3;
                        state_d = S_FAIL;
                    end
                end
            end
            S_DATA: begin
                if (byte_done) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = 9'd0;
                        cnt_d   = 3'd0;
                        state_d = S_CRC;
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end
            end
            S_CRC: begin
                if (byte_done) begin
                    if (cnt_q == 3'd0) begin
                        cnt_d = 3'd1;
                    end else begin
                        cnt_d   = 3'd0;
                        state_d = S_TRAIL;
                    end
                end
            end
            S_TRAIL: begin
                if (byte_done) state_d = S_OK;
            end
            S_OK:    state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SD_CRC16_EN
    // CRC-16/XMODEM, one whole byte folded in per strobe.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        c = crc_in ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    logic [15:0] crc_q;
    logic [15:0] crc_rx_q;
    logic        crc_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q     <= '0;
            crc_rx_q  <= '0;
            crc_err_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                crc_q     <= '0;
                crc_err_q <= 1'b0;
            end else if (dout_we) begin
                crc_q <= crc16_byte(crc_q, spi_do);
            end
            if (state_q == S_CRC && byte_done) begin
                if (cnt_q[0]) crc_rx_q[7:0]  <= spi_do;
                else          crc_rx_q[15:8] <= spi_do;
            end
            // lands in the same cycle as the done pulse
            if (state_q == S_TRAIL && byte_done) crc_err_q <= (crc_q != crc_rx_q);
        end
    end

    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

endmodule
